// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: register file geometry and instruction field positions
// used by both the register file and the decoder.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // Register index fields inside a 32-bit instruction word
   localparam int RS1_MSB = 19;
   localparam int RS1_LSB = 15;
   localparam int RS2_MSB = 24;
   localparam int RS2_LSB = 20;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 7;

endpackage

// File: rtl/porta_leitura.sv
// One combinational register-file read port: x0 returns zero, optional same-cycle
// forwarding of the write port, otherwise the stored register contents.
module porta_leitura
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int BYPASS     = 0
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] regs [1:(2**ADDR_WIDTH)-1],
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] data
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

   // x0 wins over forwarding; the write-enable already excludes x0 and reset
   always_comb begin
      data = '0;
      if (addr != ZERO_IDX) begin
         if ((BYPASS != 0) && wr_en && (wr_addr == addr))
            data = wr_data;
         else
            data = regs[addr];
      end
   end

endmodule

// File: rtl/banco_registradores.sv
// Integer register file for the single-cycle core: x1..x31 storage with one
// synchronous write port and two combinational read ports (x0 hardwired to zero).
module banco_registradores
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN,
   parameter int ADDR_WIDTH = REG_ADDR_W,
   parameter int BYPASS     = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  reg_write,
   output logic [DATA_WIDTH-1:0] rs1_data,
   output logic [DATA_WIDTH-1:0] rs2_data
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

   logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];
   logic                  wr_en;

   // Reset blocks writes and forwarding alike, so outputs stay zero while rst is high
   assign wr_en = reg_write && !rst && (rd_addr != ZERO_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < DEPTH; i++)
            regs[i] <= '0;
      end else if (wr_en) begin
         regs[rd_addr] <= rd_data;
      end
   end

   porta_leitura #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .BYPASS    (BYPASS)
   ) u_porta_rs1 (
      .addr   (rs1_addr),
      .regs   (regs),
      .wr_en  (wr_en),
      .wr_addr(rd_addr),
      .wr_data(rd_data),
      .data   (rs1_data)
   );

   porta_leitura #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .BYPASS    (BYPASS)
   ) u_porta_rs2 (
      .addr   (rs2_addr),
      .regs   (regs),
      .wr_en  (wr_en),
      .wr_addr(rd_addr),
      .wr_data(rd_data),
      .data   (rs2_data)
   );

endmodule

// File: doc/banco_registradores.md
# banco_registradores

Integer register file for the single-cycle RISC-V core: 32 general-purpose registers of 32 bits, two combinational read ports and one synchronous write port. It sits directly upstream of the ALU `ula`. `rs1_data` drives `op_a` directly. `rs2_data` drives `op_b` through the immediate mux. Write-back data, from the ALU result, memory or PC+4, returns on the write port at the end of the same instruction cycle.

## Interface
- `DATA_WIDTH`, 32: register width; must equal the ALU operand width.
- `ADDR_WIDTH`, 5: register index width; depth is 2**ADDR_WIDTH.
- `BYPASS`, 0: when 1, a same-cycle write is forwarded to the read ports. When 0, read ports show only stored contents.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `rs1_addr`  in  ADDR_WIDTH: read port 1 index (instr[19:15]).
- `rs2_addr`  in  ADDR_WIDTH: read port 2 index (instr[24:20]).
- `rd_addr`  in  ADDR_WIDTH: write index (instr[11:7]).
- `rd_data`  in  DATA_WIDTH: write data.
- `reg_write`  in  1: write enable from the main decoder.
- `rs1_data`  out  DATA_WIDTH: read port 1 value, to ALU `op_a`.
- `rs2_data`  out  DATA_WIDTH: read port 2 value, to the `op_b` mux and store data.

## Operation
- Storage: registers x1..x(2**ADDR_WIDTH-1). No storage is allocated for x0.
- x0 is hardwired to zero:
  - any read of index 0 returns 0;
  - writes with `rd_addr`=0 are discarded silently, whatever `rd_data` and `reg_write` are.
- Write: on the rising edge of `clk`, when `reg_write`=1, `rd_addr`≠0 and `rst`=0, the register at `rd_addr` takes `rd_data`. Otherwise all registers hold.
- Read: purely combinational from the addresses. There is no read enable.
- Forwarding when `BYPASS`=1: if `reg_write`=1, `rd_addr`≠0 and `rd_addr`==`rsN_addr`, then `rsN_data`=`rd_data` in the same cycle. The zero rule takes priority over forwarding.
- Forwarding when `BYPASS`=0 (single-cycle default): reads show the pre-edge value. The written value becomes visible after the edge.
- Both read ports may address the same register, including the one being written; each port resolves independently.
- Reset:
  - `rst`=1 clears every register to 0 immediately, without waiting for a clock.
  - While `rst`=1, both outputs read 0 for every address and writes are blocked.
  - A write edge that coincides with `rst` assertion is lost.
  - Deassertion takes effect at the next rising edge. The first write can occur on the first edge with `rst`=0.
- No X propagation: every register has a defined reset value.

## Timing
- Read latency: 0 cycles, combinational from `rsN_addr` and stored state (and from `rd_*` when `BYPASS`=1).
- Write latency: 1 edge. Data written at edge N reads back from N+Δ with `BYPASS`=0.
- Critical path: `rs1_addr` → 31:1 read mux → ALU → write-back → `rd_data` setup. The read mux must not add gating beyond the x0 and bypass compare.
- Reset value of outputs: `rs1_data`=`rs2_data`=0.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`=32 and `REG_ADDR_W`=5;
  - the constant `REG_ZERO`=5'd0;
  - the instruction field positions for rs1/rs2/rd, shared with the decoder.
- One sub-module is natural: `porta_leitura`, the read port with the x0 check and bypass compare. It is instantiated twice, once per read port.
- Storage and write logic stay in `banco_registradores`.

## Test plan
- Reset then read all 32 indices on both ports → all read 0. Asserting `rst` mid-run after writing x5=0xDEADBEEF returns x5 to 0 without a clock edge.
- Write x1=10 and x2=5 on consecutive edges; read rs1=1, rs2=2 → 10 and 5. Feed the ALU with `control`=00 → `result`=15.
- Write x0=0xFFFFFFFF with `reg_write`=1, then read rs1=0, rs2=0 → both 0. Under `BYPASS`=1 also 0 in the same cycle.
- Write x7=0x12345678 with `reg_write`=0 → x7 stays at its previous value (0).
- Same-cycle write x3=0xA5A5A5A5 while rs1=rs2=3:
  - `BYPASS`=0 → old value before the edge, 0xA5A5A5A5 after;
  - `BYPASS`=1 → 0xA5A5A5A5 immediately.
- Write x31=0xF0F0F0F0 and x30=0x0FF00FF0, then read both; ALU `control`=11 → `result`=0xFFF0FFF0, confirming the top index and distinct storage.
